// File: rtl/rst_release_sequencer.sv
// rst_release_sequencer: holds all domain resets, then releases them in index order, each gated by the previous domain's ready.
module rst_release_sequencer #(
  parameter int NUM_DOMAINS    = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IW = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst,
  output logic                   busy,
  output logic                   seq_done,
  output logic                   timeout_err,
  output logic [IW-1:0]          err_domain
);
  localparam int MX = HOLD_CYCLES > GAP_CYCLES ?
                      (HOLD_CYCLES > TIMEOUT_CYCLES ? HOLD_CYCLES : TIMEOUT_CYCLES) :
                      (GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES);
  localparam int CW = $clog2(MX + 1);
  typedef enum logic [2:0] {HOLD, RELEASE, GAP, DONE, ERROR} state_t;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [IW-1:0]          idx_q;
  logic [NUM_DOMAINS-1:0] dom_rst_q;
  logic                   busy_q, seq_done_q, timeout_err_q;
  logic [IW-1:0]          err_domain_q;
  always_ff @(posedge clk) begin
    if (rst || sw_rst_req) begin
      state_q       <= HOLD;
      cnt_q         <= '0;
      idx_q         <= '0;
      dom_rst_q     <= '1;
      busy_q        <= 1'b1;
      seq_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      err_domain_q  <= '0;
    end else begin
      case (state_q)
        HOLD:
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_q      <= RELEASE;
            cnt_q        <= '0;
            idx_q        <= '0;
            dom_rst_q[0] <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        RELEASE:
          // ready wins over a timeout landing on the same cycle
          if (dom_ready[idx_q]) begin
            if (idx_q == IW'(NUM_DOMAINS - 1)) begin
              state_q    <= DONE;
              busy_q     <= 1'b0;
              seq_done_q <= 1'b1;
            end else begin
              state_q <= GAP;
              cnt_q   <= '0;
            end
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_q       <= ERROR;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            err_domain_q  <= idx_q;
          end else cnt_q <= cnt_q + 1'b1;
        GAP:
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            state_q                   <= RELEASE;
            cnt_q                     <= '0;
            idx_q                     <= idx_q + 1'b1;
            dom_rst_q[idx_q + 1'b1]   <= 1'b0;
          end else cnt_q <= cnt_q + 1'b1;
        DONE, ERROR: ;
        default: state_q <= HOLD;
      endcase
    end
  end
  assign dom_rst     = dom_rst_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign timeout_err = timeout_err_q;
  assign err_domain  = err_domain_q;
endmodule

// File: tb/tb_rst_release_sequencer.sv
// tb_rst_release_sequencer: directed vector table for a 4-domain sequencer plus a hand sequence for a 1-domain one.
module tb_rst_release_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1, sw = 1'b0, rst1 = 1'b1;
  logic [3:0] rdy = 4'h0;
  logic [3:0] dom_rst;
  logic       busy, seq_done, timeout_err;
  logic [1:0] err_domain;
  logic       dom_rst1, busy1, seq_done1, timeout_err1;
  logic       err_domain1;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  rst_release_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .sw_rst_req(sw), .dom_ready(rdy), .dom_rst(dom_rst), .busy(busy),
    .seq_done(seq_done), .timeout_err(timeout_err), .err_domain(err_domain));

  rst_release_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(16), .GAP_CYCLES(4), .TIMEOUT_CYCLES(32)) dut1 (
    .clk(clk), .rst(rst1), .sw_rst_req(1'b0), .dom_ready(1'b1), .dom_rst(dom_rst1), .busy(busy1),
    .seq_done(seq_done1), .timeout_err(timeout_err1), .err_domain(err_domain1));

  typedef struct {
    string      name;
    int         n;
    logic       r, s;
    logic [3:0] rdy;
    logic [8:0] exp;
  } vec_t;
  vec_t v[$];

  function automatic void add(string nm, int n, logic r, logic s, logic [3:0] rd,
                              logic [3:0] dr, logic b, logic d, logic e, logic [1:0] ed);
    vec_t t;
    t.name = nm; t.n = n; t.r = r; t.s = s; t.rdy = rd; t.exp = {dr, b, d, e, ed};
    v.push_back(t);
  endfunction

  task automatic chk(string nm, logic [8:0] act, logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // single-domain instance: ready tied high, DONE one cycle after release
    step(2);
    chk("n1_reset", {4'h0, dom_rst1, busy1, seq_done1, timeout_err1, err_domain1}, 9'b1_1000);
    rst1 = 1'b0;
    step(15);
    chk("n1_hold", {4'h0, dom_rst1, busy1, seq_done1, timeout_err1, err_domain1}, 9'b1_1000);
    step(1);
    chk("n1_rel", {4'h0, dom_rst1, busy1, seq_done1, timeout_err1, err_domain1}, 9'b0_1000);
    step(1);
    chk("n1_done", {4'h0, dom_rst1, busy1, seq_done1, timeout_err1, err_domain1}, 9'b0_0100);
    step(3);
    chk("n1_stay", {4'h0, dom_rst1, busy1, seq_done1, timeout_err1, err_domain1}, 9'b0_0100);

    //   name        n  r  s  rdy    dom_rst b  d  e  ed
    add("rst",       3, 1, 0, 4'h0, 4'hF, 1, 0, 0, 0);
    add("hold15",   15, 0, 0, 4'h0, 4'hF, 1, 0, 0, 0);
    add("rel0",      1, 0, 0, 4'h0, 4'hE, 1, 0, 0, 0);
    add("wait0",     2, 0, 0, 4'h0, 4'hE, 1, 0, 0, 0);
    add("gap0",      4, 0, 0, 4'h1, 4'hE, 1, 0, 0, 0);
    add("rel1",      1, 0, 0, 4'h1, 4'hC, 1, 0, 0, 0);
    add("wait1",     2, 0, 0, 4'h1, 4'hC, 1, 0, 0, 0);
    add("gap1",      4, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("rel2",      1, 0, 0, 4'h3, 4'h8, 1, 0, 0, 0);
    add("wait2",     2, 0, 0, 4'h3, 4'h8, 1, 0, 0, 0);
    add("gap2",      4, 0, 0, 4'h7, 4'h8, 1, 0, 0, 0);
    add("rel3",      1, 0, 0, 4'h7, 4'h0, 1, 0, 0, 0);
    add("wait3",     2, 0, 0, 4'h7, 4'h0, 1, 0, 0, 0);
    add("done",      1, 0, 0, 4'hF, 4'h0, 0, 1, 0, 0);
    add("done_hold", 5, 0, 0, 4'h0, 4'h0, 0, 1, 0, 0);
    add("sw_done",   1, 0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    add("hold_a",   15, 0, 0, 4'h3, 4'hF, 1, 0, 0, 0);
    add("rel0_a",    1, 0, 0, 4'h3, 4'hE, 1, 0, 0, 0);
    add("gap0_a",    4, 0, 0, 4'h3, 4'hE, 1, 0, 0, 0);
    add("rel1_a",    1, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("gap1_a",    4, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("rel2_a",    1, 0, 0, 4'h3, 4'h8, 1, 0, 0, 0);
    add("to_wait",  31, 0, 0, 4'h3, 4'h8, 1, 0, 0, 0);
    add("timeout",   1, 0, 0, 4'h3, 4'h8, 0, 0, 1, 2);
    add("err_hold",  3, 0, 0, 4'h7, 4'h8, 0, 0, 1, 2);
    add("sw_err",    1, 0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    add("hold10",   10, 0, 0, 4'h0, 4'hF, 1, 0, 0, 0);
    add("sw_hold",   1, 0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    add("hold_b",   15, 0, 0, 4'h1, 4'hF, 1, 0, 0, 0);
    add("rel0_b",    1, 0, 0, 4'h1, 4'hE, 1, 0, 0, 0);
    add("gap0_b",    4, 0, 0, 4'h1, 4'hE, 1, 0, 0, 0);
    add("rel1_b",    1, 0, 0, 4'h1, 4'hC, 1, 0, 0, 0);
    add("to_edge",  31, 0, 0, 4'h1, 4'hC, 1, 0, 0, 0);
    add("late_rdy",  1, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("gap1_b",    3, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("rel2_b",    1, 0, 0, 4'h3, 4'h8, 1, 0, 0, 0);
    add("gap2_b",    4, 0, 0, 4'h7, 4'h8, 1, 0, 0, 0);
    add("rel3_b",    1, 0, 0, 4'h7, 4'h0, 1, 0, 0, 0);
    add("done_b",    1, 0, 0, 4'hF, 4'h0, 0, 1, 0, 0);
    add("sw_c",      1, 0, 1, 4'h0, 4'hF, 1, 0, 0, 0);
    add("hold_c",   15, 0, 0, 4'h3, 4'hF, 1, 0, 0, 0);
    add("rel0_c",    1, 0, 0, 4'h3, 4'hE, 1, 0, 0, 0);
    add("gap0_c",    4, 0, 0, 4'h3, 4'hE, 1, 0, 0, 0);
    add("rel1_c",    1, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("gap1_c",    2, 0, 0, 4'h3, 4'hC, 1, 0, 0, 0);
    add("rst_gap",   1, 1, 0, 4'h3, 4'hF, 1, 0, 0, 0);
    add("hold_d",   15, 0, 0, 4'h3, 4'hF, 1, 0, 0, 0);
    add("rel0_d",    1, 0, 0, 4'h3, 4'hE, 1, 0, 0, 0);

    foreach (v[i]) begin
      rst = v[i].r;
      sw  = v[i].s;
      rdy = v[i].rdy;
      step(v[i].n);
      chk(v[i].name, {dom_rst, busy, seq_done, timeout_err, err_domain}, v[i].exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
